// File: rtl/conv_mac_engine.sv
// conv_mac_engine: per-channel signed K*K-tap multiply-accumulate.
// Operands are captured on start. Products are registered, then reduced through a pipelined
// pairwise adder tree. Each result is held until the controller releases MULTIPLY_START.
module conv_mac_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNELS    = 3,
  parameter int ACC_WIDTH   = 72,
  parameter bit SATURATE    = 1'b1,
  localparam int K_SQUARED  = KERNEL_SIZE * KERNEL_SIZE
) (
  input  logic                                      axi_clk,
  input  logic                                      axi_reset,
  input  logic [K_SQUARED-1:0]                      MULTIPLY_START,
  input  logic [CHANNELS*K_SQUARED*DATA_WIDTH-1:0]  MULTIPLIER_INPUT,
  input  logic [CHANNELS*K_SQUARED*DATA_WIDTH-1:0]  MULTIPLICAND_INPUT,
  output logic [CHANNELS*DATA_WIDTH-1:0]            cSum,
  output logic                                      cReady,
  output logic                                      busy,
  output logic [CHANNELS-1:0]                       sat_flag,
  output logic [15:0]                               conv_count
);

  localparam int L  = $clog2(K_SQUARED);
  localparam int SW = $clog2(L + 2);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int BW = CHANNELS * K_SQUARED * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state_q, state_d;
  logic [SW-1:0]                 stage_q, stage_d;
  logic [BW-1:0]                 opa_q, opa_d, opb_q, opb_d;
  logic [ACC_WIDTH-1:0]          tree_q [CHANNELS][K_SQUARED];
  logic [ACC_WIDTH-1:0]          tree_d [CHANNELS][K_SQUARED];
  logic [CHANNELS*DATA_WIDTH-1:0] csum_q, csum_d;
  logic                          cready_q, cready_d;
  logic [CHANNELS-1:0]           sat_q, sat_d;
  logic [15:0]                   count_q, count_d;

  logic                          go;
  logic signed [PW-1:0]          prod [CHANNELS][K_SQUARED];
  logic [ACC_WIDTH-1:0]          lvl  [CHANNELS][K_SQUARED];
  logic [CHANNELS*DATA_WIDTH-1:0] res;
  logic [CHANNELS-1:0]           res_sat;

  assign go = &MULTIPLY_START;

  // Full-width signed products of the captured operands (both sign-extended to PW first).
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      for (int t = 0; t < K_SQUARED; t++) begin
        prod[c][t] = $signed({{DATA_WIDTH{opa_q[(c*K_SQUARED+t)*DATA_WIDTH + DATA_WIDTH-1]}},
                              opa_q[(c*K_SQUARED+t)*DATA_WIDTH +: DATA_WIDTH]})
                   * $signed({{DATA_WIDTH{opb_q[(c*K_SQUARED+t)*DATA_WIDTH + DATA_WIDTH-1]}},
                              opb_q[(c*K_SQUARED+t)*DATA_WIDTH +: DATA_WIDTH]});
      end
    end
  end

  // One adder-tree level: pairs sum into the low half, an odd tail passes through, the rest clear.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < K_SQUARED; k++) lvl[c][k] = '0;
      for (int k = 0; k < K_SQUARED / 2; k++) lvl[c][k] = tree_q[c][2*k] + tree_q[c][2*k+1];
      if (K_SQUARED % 2 == 1) lvl[c][K_SQUARED/2] = tree_q[c][K_SQUARED-1];
    end
  end

  // Output formatting of the final level: clamp when the sum leaves the signed DATA_WIDTH range.
  always_comb begin
    res     = '0;
    res_sat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      res[c*DATA_WIDTH +: DATA_WIDTH] = lvl[c][0][DATA_WIDTH-1:0];
      if (SATURATE && !((&lvl[c][0][ACC_WIDTH-1:DATA_WIDTH-1]) ||
                        (~|lvl[c][0][ACC_WIDTH-1:DATA_WIDTH-1]))) begin
        res_sat[c] = 1'b1;
        res[c*DATA_WIDTH +: DATA_WIDTH] = lvl[c][0][ACC_WIDTH-1] ?
          {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end
  end

  // Sequencer: stage 0 of RUN registers products, stages 1..L register tree levels.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    tree_d   = tree_q;
    csum_d   = csum_q;
    cready_d = cready_q;
    sat_d    = sat_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          opa_d   = MULTIPLIER_INPUT;
          opb_d   = MULTIPLICAND_INPUT;
          stage_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!go) begin
          state_d = IDLE;
          stage_d = '0;
        end else if (stage_q == '0) begin
          for (int c = 0; c < CHANNELS; c++)
            for (int t = 0; t < K_SQUARED; t++)
              tree_d[c][t] = {{(ACC_WIDTH-PW){prod[c][t][PW-1]}}, prod[c][t]};
          stage_d = SW'(1);
        end else begin
          tree_d  = lvl;
          stage_d = stage_q + SW'(1);
          if (stage_q == SW'(L)) begin
            state_d  = DONE;
            cready_d = 1'b1;
            csum_d   = res;
            sat_d    = res_sat;
            count_d  = count_q + 16'd1;
          end
        end
      end
      DONE: begin
        if (!go) begin
          state_d  = IDLE;
          cready_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers; reset discards any in-flight work.
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q  <= IDLE;
      stage_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < K_SQUARED; t++) tree_q[c][t] <= '0;
      csum_q   <= '0;
      cready_q <= 1'b0;
      sat_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      tree_q   <= tree_d;
      csum_q   <= csum_d;
      cready_q <= cready_d;
      sat_q    <= sat_d;
      count_q  <= count_d;
    end
  end

  assign cSum       = csum_q;
  assign cReady     = cready_q;
  assign busy       = (state_q != IDLE);
  assign sat_flag   = sat_q;
  assign conv_count = count_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine: a saturating and a wrapping instance share one stimulus.
module tb_conv_mac_engine;

  localparam int DW = 32;
  localparam int KS = 9;
  localparam int CH = 3;
  localparam int BW = CH * KS * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [KS-1:0] start;
  logic [BW-1:0] din, fin;

  logic [CH*DW-1:0] sum_s, sum_r;
  logic             rdy_s, rdy_r, busy_s, busy_r;
  logic [CH-1:0]    sat_s, sat_r;
  logic [15:0]      cnt_s, cnt_r;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  conv_mac_engine #(.SATURATE(1'b1)) u_sat (
    .axi_clk(clk), .axi_reset(rst), .MULTIPLY_START(start),
    .MULTIPLIER_INPUT(din), .MULTIPLICAND_INPUT(fin),
    .cSum(sum_s), .cReady(rdy_s), .busy(busy_s), .sat_flag(sat_s), .conv_count(cnt_s));

  conv_mac_engine #(.SATURATE(1'b0)) u_raw (
    .axi_clk(clk), .axi_reset(rst), .MULTIPLY_START(start),
    .MULTIPLIER_INPUT(din), .MULTIPLICAND_INPUT(fin),
    .cSum(sum_r), .cReady(rdy_r), .busy(busy_r), .sat_flag(sat_r), .conv_count(cnt_r));

  typedef struct {
    logic [BW-1:0]    din;
    logic [BW-1:0]    fin;
    logic [CH*DW-1:0] sum_sat;
    logic [CH-1:0]    flg_sat;
    logic [CH*DW-1:0] sum_raw;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] fill3(input logic [31:0] v0, input logic [31:0] v1,
                                          input logic [31:0] v2);
    logic [BW-1:0] b;
    for (int t = 0; t < KS; t++) begin
      b[(0*KS+t)*DW +: DW] = v0;
      b[(1*KS+t)*DW +: DW] = v1;
      b[(2*KS+t)*DW +: DW] = v2;
    end
    return b;
  endfunction

  task automatic check_reset_zero(input string tag);
    chk({tag, "_sum"},   sum_s,  '0);
    chk({tag, "_ready"}, rdy_s,  '0);
    chk({tag, "_busy"},  busy_s, '0);
    chk({tag, "_sat"},   sat_s,  '0);
    chk({tag, "_count"}, cnt_s,  '0);
  endtask

  // Start an operation, scramble inputs after capture, measure latency, check, optionally release.
  task automatic run_op(input int v, input int hold, input bit drop);
    int n;
    din   = vecs[v].din;
    fin   = vecs[v].fin;
    start = '1;
    tick();
    n = 1;
    for (int i = 0; i < CH*KS; i++) begin
      din[i*DW +: DW] = $urandom();
      fin[i*DW +: DW] = $urandom();
    end
    while (!rdy_s && n < 20) begin
      tick();
      n++;
    end
    exp_count++;
    chk($sformatf("v%0d_latency", v), n, 6);
    chk($sformatf("v%0d_sum_sat", v), sum_s, vecs[v].sum_sat);
    chk($sformatf("v%0d_flag_sat", v), sat_s, vecs[v].flg_sat);
    chk($sformatf("v%0d_sum_raw", v), sum_r, vecs[v].sum_raw);
    chk($sformatf("v%0d_flag_raw", v), sat_r, '0);
    chk($sformatf("v%0d_count", v), cnt_s, exp_count);
    chk($sformatf("v%0d_busy", v), busy_s, 1);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk($sformatf("v%0d_hold%0d", v, h), {rdy_s, sat_s, cnt_s, sum_s},
          {1'b1, vecs[v].flg_sat, 16'(exp_count), vecs[v].sum_sat});
    end
    if (drop) begin
      start = '0;
      tick();
      chk($sformatf("v%0d_rel_ready", v), rdy_s, 0);
      chk($sformatf("v%0d_rel_busy", v), busy_s, 0);
      chk($sformatf("v%0d_rel_sum", v), sum_s, vecs[v].sum_sat);
    end
  endtask

  initial begin
    // 0: all ones
    vecs[0].din = fill3(32'd1, 32'd1, 32'd1);
    vecs[0].fin = fill3(32'd1, 32'd1, 32'd1);
    vecs[0].sum_sat = {32'd9, 32'd9, 32'd9};
    vecs[0].flg_sat = 3'b000;
    vecs[0].sum_raw = {32'd9, 32'd9, 32'd9};
    // 1: ch0 -1*2, ch1 t*t (sum of squares 0..8 = 204), ch2 zeros
    vecs[1].din = fill3(32'hFFFFFFFF, 32'd0, 32'd0);
    vecs[1].fin = fill3(32'd2, 32'd0, 32'd0);
    for (int t = 0; t < KS; t++) begin
      vecs[1].din[(1*KS+t)*DW +: DW] = 32'(t);
      vecs[1].fin[(1*KS+t)*DW +: DW] = 32'(t);
    end
    vecs[1].sum_sat = {32'd0, 32'd204, 32'hFFFFFFEE};
    vecs[1].flg_sat = 3'b000;
    vecs[1].sum_raw = {32'd0, 32'd204, 32'hFFFFFFEE};
    // 2: max*max -> positive clamp; exact sum low word is 9
    vecs[2].din = fill3(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    vecs[2].fin = fill3(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    vecs[2].sum_sat = {3{32'h7FFFFFFF}};
    vecs[2].flg_sat = 3'b111;
    vecs[2].sum_raw = {3{32'd9}};
    // 3: max*min -> negative clamp; exact sum low word is 0x80000000
    vecs[3].din = fill3(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    vecs[3].fin = fill3(32'h80000000, 32'h80000000, 32'h80000000);
    vecs[3].sum_sat = {3{32'h80000000}};
    vecs[3].flg_sat = 3'b111;
    vecs[3].sum_raw = {3{32'h80000000}};
    // 4: boundaries: exactly max, one below min, one above max
    vecs[4].din = fill3(32'd0, 32'd0, 32'd0);
    vecs[4].fin = fill3(32'd1, 32'd1, 32'd1);
    vecs[4].din[(0*KS+0)*DW +: DW] = 32'h7FFFFFFF;
    vecs[4].din[(1*KS+0)*DW +: DW] = 32'h80000000;
    vecs[4].din[(1*KS+1)*DW +: DW] = 32'hFFFFFFFF;
    vecs[4].din[(2*KS+0)*DW +: DW] = 32'h7FFFFFFF;
    vecs[4].din[(2*KS+1)*DW +: DW] = 32'd1;
    vecs[4].sum_sat = {32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    vecs[4].flg_sat = 3'b110;
    vecs[4].sum_raw = {32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
    // 5: exactly min, (-1)*(-1)*9, 3*(-5)*9 = -135
    vecs[5].din = fill3(32'd0, 32'hFFFFFFFF, 32'd3);
    vecs[5].fin = fill3(32'd1, 32'hFFFFFFFF, 32'hFFFFFFFB);
    vecs[5].din[(0*KS+0)*DW +: DW] = 32'h80000000;
    vecs[5].sum_sat = {32'hFFFFFF79, 32'd9, 32'h80000000};
    vecs[5].flg_sat = 3'b000;
    vecs[5].sum_raw = {32'hFFFFFF79, 32'd9, 32'h80000000};

    rst   = 1'b1;
    start = '0;
    din   = '0;
    fin   = '0;
    repeat (3) tick();
    check_reset_zero("reset");
    rst = 1'b0;
    tick();
    chk("post_reset_busy", busy_s, 0);

    for (int v = 0; v < 6; v++) run_op(v, 2, 1'b1);

    // long hold in DONE, then release and restart
    run_op(0, 10, 1'b1);
    run_op(1, 0, 1'b1);

    // abort three cycles into RUN
    din   = vecs[2].din;
    fin   = vecs[2].fin;
    start = '1;
    repeat (3) tick();
    chk("abort_busy_run", busy_s, 1);
    start = '0;
    tick();
    chk("abort_busy", busy_s, 0);
    repeat (8) tick();
    chk("abort_ready", rdy_s, 0);
    chk("abort_count", cnt_s, exp_count);
    chk("abort_sum", sum_s, vecs[1].sum_sat);

    // partial start vector is ignored
    start = 9'h0FF;
    repeat (8) tick();
    chk("partial_busy", busy_s, 0);
    chk("partial_ready", rdy_s, 0);
    chk("partial_count", cnt_s, exp_count);
    start = '0;
    tick();

    // reset asserted mid-RUN
    din   = vecs[0].din;
    fin   = vecs[0].fin;
    start = '1;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1 check_reset_zero("rst_run");
    exp_count = 0;
    start = '0;
    tick();
    rst = 1'b0;
    tick();
    run_op(1, 1, 1'b1);

    // reset asserted while holding in DONE
    run_op(2, 2, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_zero("rst_done");
    exp_count = 0;
    start = '0;
    tick();
    rst = 1'b0;
    tick();
    run_op(5, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
